// File: rtl/dsram_slave.sv
`default_nettype none
// ============================================================================
//  Module   : dsram_slave
//  Purpose  : Data-SRAM slave with a 2-entry in-order request queue and an
//             extra configurable wait for uncached accesses.
//  Revision : 1.0
// ============================================================================
module dsram_slave #(
    parameter int ADDR_W   = 10,
    parameter int UC_DELAY = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    input  logic        data_uncache,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata
);

    localparam int   c_DEPTH = 1 << ADDR_W;
    localparam int   c_CNT_W = (UC_DELAY < 2) ? 1 : $clog2(UC_DELAY + 1);
    localparam logic c_UC_EN = (UC_DELAY != 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [c_CNT_W-1:0]  r_wait_cnt;

    logic                r_q_wr    [2];
    logic [3:0]          r_q_strb  [2];
    logic [ADDR_W-1:0]   r_q_idx   [2];
    logic [31:0]         r_q_wdata [2];
    logic                r_q_uc    [2];
    logic                r_wptr;
    logic                r_rptr;
    logic [1:0]          r_count;

    logic [31:0]         r_mem [c_DEPTH];
    logic [31:0]         r_rdata;

    logic                w_addr_ok;
    logic                w_push;
    logic                w_pop;
    logic                w_head_wr;
    logic [3:0]          w_head_strb;
    logic [ADDR_W-1:0]   w_head_idx;
    logic [31:0]         w_head_wdata;
    logic                w_head_uc;
    logic                w_unused;

    // Transfer size and the byte/out-of-range address bits never select storage.
    assign w_unused = ^{data_sram_size, data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

    assign w_addr_ok    = (r_count < 2'd2);
    assign w_push       = data_sram_req & w_addr_ok & ~reset;
    assign w_pop        = (r_state == S_RESP);

    assign w_head_wr    = r_q_wr[r_rptr];
    assign w_head_strb  = r_q_strb[r_rptr];
    assign w_head_idx   = r_q_idx[r_rptr];
    assign w_head_wdata = r_q_wdata[r_rptr];
    assign w_head_uc    = r_q_uc[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_wr[r_wptr]    <= data_sram_wr;
            r_q_strb[r_wptr]  <= data_sram_wstrb;
            r_q_idx[r_wptr]   <= data_sram_addr[ADDR_W+1:2];
            r_q_wdata[r_wptr] <= data_sram_wdata;
            r_q_uc[r_wptr]    <= data_uncache;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) r_wptr <= ~r_wptr;
            if (w_pop)  r_rptr <= ~r_rptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_count != 2'd0) begin
                    if (w_head_uc && c_UC_EN) w_next = S_WAIT;
                    else                      w_next = S_ACCESS;
                end
            end
            S_WAIT:   if (r_wait_cnt == c_CNT_W'(1)) w_next = S_ACCESS;
            S_ACCESS: w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_IDLE && w_next == S_WAIT) begin
            r_wait_cnt <= c_CNT_W'(UC_DELAY);
        end else if (r_state == S_WAIT) begin
            r_wait_cnt <= r_wait_cnt - c_CNT_W'(1);
        end
    end

    // Memory has no reset so its contents survive a mid-operation reset.
    always_ff @(posedge clk) begin
        if (!reset && r_state == S_ACCESS && w_head_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (w_head_strb[i]) r_mem[w_head_idx][8*i +: 8] <= w_head_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= 32'd0;
        end else if (r_state == S_ACCESS && !w_head_wr) begin
            r_rdata <= r_mem[w_head_idx];
        end
    end

    assign data_sram_addr_ok = w_addr_ok;
    assign data_sram_data_ok = (r_state == S_RESP);
    assign data_sram_rdata   = r_rdata;

endmodule
`default_nettype wire

// File: doc/dsram_slave.md
DSRAM_SLAVE -- requirements
Module: dsram_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning word-address bits of the internal memory (1024 x 32-bit words).
REQ-002 SHALL have parameter UC_DELAY, default 4, meaning extra wait cycles for uncached requests (0 = same timing as cached).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port `clk`, input, 1 bit: the single clock.
REQ-005 SHALL have port `reset`, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port `data_sram_req`, input, 1 bit: request valid.
REQ-007 SHALL have port `data_sram_wr`, input, 1 bit: 1 = write, 0 = read.
REQ-008 SHALL have port `data_sram_size`, input, 2 bits: 0 = byte, 1 = half, 2 = word.
REQ-009 SHALL have port `data_sram_wstrb`, input, 4 bits: byte write enables.
REQ-010 SHALL have port `data_sram_addr`, input, 32 bits: byte address.
REQ-011 SHALL have port `data_sram_wdata`, input, 32 bits: write data.
REQ-012 SHALL have port `data_uncache`, input, 1 bit: the request is uncached.
REQ-013 SHALL have port `data_sram_addr_ok`, output, 1 bit: request accepted this cycle.
REQ-014 SHALL have port `data_sram_data_ok`, output, 1 bit: response for the oldest accepted request.
REQ-015 SHALL have port `data_sram_rdata`, output, 32 bits: read data, valid when data_ok is 1 for a read.

Function
REQ-016 SHALL accept a request on a rising edge where data_sram_req and data_sram_addr_ok are both 1; the accepted fields are wr, size, wstrb, addr[ADDR_W+1:2], wdata and uncache.
REQ-017 SHALL hold accepted requests in a 2-entry in-order request queue.
REQ-018 SHALL drive data_sram_addr_ok = (queue count < 2), independent of data_sram_req, with no same-cycle pop bypass.
REQ-019 SHALL sequence the queue head with an FSM having states IDLE, WAIT, ACCESS and RESP.
REQ-020 In IDLE with the queue non-empty, the FSM SHALL go to ACCESS if the head is cached or UC_DELAY=0, else load wait counter = UC_DELAY and go to WAIT.
REQ-021 In WAIT the FSM SHALL decrement the counter each cycle and go to ACCESS on the cycle the counter reads 1.
REQ-022 ACCESS, read: SHALL register mem[addr] (full word) into data_sram_rdata, then go to RESP.
REQ-023 ACCESS, write: SHALL update each byte i of mem[addr] where wstrb[i]=1, leave rdata unchanged, then go to RESP.
REQ-024 ACCESS, write with wstrb=0: SHALL be a no-op write that still produces a response.
REQ-025 RESP SHALL assert data_sram_data_ok for exactly one cycle, pop the queue head, and return to IDLE.
REQ-026 SHALL produce exactly one data_ok per accepted request (reads and writes), in acceptance order.
REQ-027 Cached latency: for acceptance at edge E, data_ok SHALL be 1 in the third cycle after E (E+1 IDLE, E+2 ACCESS, E+3 RESP).
REQ-028 Uncached latency SHALL be the cached latency + UC_DELAY cycles.
REQ-029 Simultaneous accept and RESP pop in the same cycle SHALL both take effect; the count is unchanged.
REQ-030 With the queue full, a request SHALL be neither accepted nor lost; the requester holds it until addr_ok returns.
REQ-031 A read of an address written by an earlier accepted request SHALL return the written data (in-order ACCESS guarantees this).
REQ-032 data_sram_size SHALL NOT alter memory behaviour; wstrb alone governs byte lanes; addr[1:0] and addr[31:ADDR_W+2] SHALL be ignored for indexing.
REQ-033 data_sram_rdata SHALL hold its last value outside RESP.

Reset
REQ-034 On reset, SHALL clear the queue count and pointers, set the FSM to IDLE, set the wait counter to 0, data_sram_data_ok to 0 and data_sram_rdata to 0; data_sram_addr_ok is therefore 1 in the first cycle after reset.
REQ-035 Reset mid-operation (any state, queue partially full) SHALL discard all pending requests with no data_ok issued for them; memory contents SHALL be preserved.
REQ-036 A request presented in a reset cycle SHALL NOT be accepted.

Verification
REQ-037 Write then read: write addr 0x00000010, wdata 0xDEADBEEF, wstrb 4'hF, cached; then read 0x00000010 -> two data_ok pulses in order; the second carries rdata 0xDEADBEEF, and the first data_ok is 3 cycles after acceptance.
REQ-038 Byte strobe: preload 0x11223344 at 0x20, write wdata 0xAABBCCDD with wstrb 4'b0101, then read -> rdata 0x11BB33DD.
REQ-039 Back-pressure: issue 3 back-to-back cached reads -> addr_ok falls after the second acceptance, the third is accepted when the count drops, and 3 data_ok pulses arrive in order with correct data.
REQ-040 Uncached timing: uncached read with UC_DELAY=4 -> data_ok 7 cycles after acceptance; a cached read queued behind it responds after it, never before.
REQ-041 Reset in WAIT: accept an uncached read, assert reset for 1 cycle during WAIT -> no data_ok ever for that request; addr_ok=1 and data_ok=0 after reset; previously written memory still reads back correctly.
REQ-042 Simultaneous accept/pop: a full queue with the head in RESP plus a new req -> the new request is accepted the cycle after RESP (addr_ok was 0 during RESP), with no loss and no duplicate data_ok.
